// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if
//   Bundle between the multicycle RV32I main controller and the datapath /
//   memory side.
//   master : the controller (drives the control outputs, reads op/mem_ready)
//   slave  : the datapath and memory (drive op/mem_ready, read the controls)
//   Signals:
//     op[6:0]        opcode field from the instruction register
//     mem_ready      memory completes the current request this cycle
//     pc_update      PC write enable
//     branch         conditional PC update (beq)
//     reg_write      register file write enable
//     mem_write      data memory write enable
//     ir_write       instruction register / OldPC write enable
//     mem_req        memory access in progress
//     adr_src        memory address select (0: PC, 1: ALUOut)
//     result_src[1:0] 00: ALUOut, 01: Data, 10: ALUResult
//     alu_src_a[1:0]  00: PC, 01: OldPC, 10: rs1, 11: zero
//     alu_src_b[1:0]  00: rs2, 01: ImmExt, 10: 4
//     alu_op[1:0]     00: add, 01: sub/compare, 10: funct-decoded
//     illegal_op     high while trapped
//     retire         one-cycle pulse in the last cycle of an instruction
//     state_o[3:0]   current controller state (debug)
interface mc_control_fsm_if;
    logic [6:0] op;
    logic       mem_ready;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       mem_req;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       retire;
    logic [3:0] state_o;

    modport master (
        input  op, mem_ready,
        output pc_update, branch, reg_write, mem_write, ir_write, mem_req,
               adr_src, result_src, alu_src_a, alu_src_b, alu_op,
               illegal_op, retire, state_o
    );

    modport slave (
        output op, mem_ready,
        input  pc_update, branch, reg_write, mem_write, ir_write, mem_req,
               adr_src, result_src, alu_src_a, alu_src_b, alu_op,
               illegal_op, retire, state_o
    );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Main controller for the multicycle RV32I core. Decodes the opcode and
//   sequences fetch / decode / execute / writeback, with a memory ready
//   handshake, optional jalr/lui/auipc support and an illegal-opcode trap.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; forces FETCH immediately
//     bus    mc_control_fsm_if.master (op, mem_ready in; datapath controls out)
//   Parameters:
//     MEM_WAIT_EN  1: fetch/load/store wait for mem_ready; 0: mem_ready ignored
//     EXT_OPS      1: decode jalr/lui/auipc; 0: treat them as illegal
//     TRAP_EN      1: illegal op traps until reset; 0: illegal op retires as nop
//
//   state | meaning
//   ------+--------------------------------------------------------------
//    0    | FETCH    read instruction at PC, PC <- PC+4 when memory ready
//    1    | DECODE   read registers, compute branch/jump target, dispatch
//    2    | MEMADR   rs1 + imm for lw/sw
//    3    | MEMREAD  data read, wait for memory
//    4    | MEMWB    load data -> rd
//    5    | MEMWRITE data write, wait for memory
//    6    | EXECR    R-type ALU operation
//    7    | ALUWB    ALUOut -> rd
//    8    | EXECI    I-type ALU operation
//    9    | JAL      PC <- target, ALUOut <- OldPC+4
//    10   | BEQ      compare and conditionally branch
//    11   | JALRADR  rs1 + imm
//    12   | JALR     PC <- rs1+imm, ALUOut <- OldPC+4
//    13   | LUI      0 + imm
//    14   | AUIPC    OldPC + imm
//    15   | TRAP     illegal opcode, sticky until reset
module mc_control_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit EXT_OPS     = 1'b1,
    parameter bit TRAP_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_JALRADR  = 4'd11,
        S_JALR     = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    state_t state;
    state_t state_nxt;

    logic       rdy;
    logic       op_illegal;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       mem_req;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       retire;

    // With the handshake disabled every memory access completes at once.
    assign rdy = bus.mem_ready | ~MEM_WAIT_EN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        op_illegal = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        retire     = 1'b0;

        unique case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = 2'b00;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // PC and IR only load in the cycle memory actually returns data.
                ir_write   = rdy;
                pc_update  = rdy;
                if (rdy) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_JALR: begin
                        if (EXT_OPS) state_nxt = S_JALRADR;
                        else         op_illegal = 1'b1;
                    end
                    OP_LUI: begin
                        if (EXT_OPS) state_nxt = S_LUI;
                        else         op_illegal = 1'b1;
                    end
                    OP_AUIPC: begin
                        if (EXT_OPS) state_nxt = S_AUIPC;
                        else         op_illegal = 1'b1;
                    end
                    default:      op_illegal = 1'b1;
                endcase
                // Without a trap the illegal op retires as a nop; the PC was
                // already advanced in FETCH.
                if (op_illegal) begin
                    if (TRAP_EN) begin
                        state_nxt = S_TRAP;
                    end else begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                    end
                end
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
                if (rdy) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
                retire    = rdy;
                if (rdy) state_nxt = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b00;
                pc_update  = 1'b1;
                state_nxt  = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JALRADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = S_JALR;
            end
            S_JALR: begin
                // ALUOut holds rs1+imm for the PC while the ALU forms OldPC+4.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b00;
                pc_update  = 1'b1;
                state_nxt  = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_nxt = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_nxt = S_ALUWB;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign bus.pc_update  = pc_update;
    assign bus.branch     = branch;
    assign bus.reg_write  = reg_write;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.mem_req    = mem_req;
    assign bus.adr_src    = adr_src;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.illegal_op = illegal_op;
    assign bus.retire     = retire;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
//   Bench for mc_control_fsm. Three instances share op/mem_ready/reset:
//     dut0: MEM_WAIT_EN=1 EXT_OPS=1 TRAP_EN=1
//     dut1: MEM_WAIT_EN=1 EXT_OPS=0 TRAP_EN=1
//     dut2: MEM_WAIT_EN=0 EXT_OPS=0 TRAP_EN=0
//   A per-instance instruction-path model predicts every output each cycle;
//   directed literal checks pin latencies and key outputs.
module tb_mc_control_fsm;

    localparam int N = 3;
    localparam bit [N-1:0] P_MW   = 3'b011;
    localparam bit [N-1:0] P_EXT  = 3'b001;
    localparam bit [N-1:0] P_TRAP = 3'b011;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic       mem_ready = 1'b1;

    always #5 clk = ~clk;

    mc_control_fsm_if bus0 ();
    mc_control_fsm_if bus1 ();
    mc_control_fsm_if bus2 ();

    assign bus0.op = op;
    assign bus0.mem_ready = mem_ready;
    assign bus1.op = op;
    assign bus1.mem_ready = mem_ready;
    assign bus2.op = op;
    assign bus2.mem_ready = mem_ready;

    mc_control_fsm #(.MEM_WAIT_EN(1'b1), .EXT_OPS(1'b1), .TRAP_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master));
    mc_control_fsm #(.MEM_WAIT_EN(1'b1), .EXT_OPS(1'b0), .TRAP_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.master));
    mc_control_fsm #(.MEM_WAIT_EN(1'b0), .EXT_OPS(1'b0), .TRAP_EN(1'b0)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.master));

    // {state[20:17], pc_update, branch, reg_write, mem_write[13], ir_write[12],
    //  mem_req, adr_src, result_src[9:8], a[7:6], b[5:4], alu_op[3:2], illegal_op, retire[0]}
    logic [20:0] act [N];
    assign act[0] = {bus0.state_o, bus0.pc_update, bus0.branch, bus0.reg_write, bus0.mem_write,
                     bus0.ir_write, bus0.mem_req, bus0.adr_src, bus0.result_src, bus0.alu_src_a,
                     bus0.alu_src_b, bus0.alu_op, bus0.illegal_op, bus0.retire};
    assign act[1] = {bus1.state_o, bus1.pc_update, bus1.branch, bus1.reg_write, bus1.mem_write,
                     bus1.ir_write, bus1.mem_req, bus1.adr_src, bus1.result_src, bus1.alu_src_a,
                     bus1.alu_src_b, bus1.alu_op, bus1.illegal_op, bus1.retire};
    assign act[2] = {bus2.state_o, bus2.pc_update, bus2.branch, bus2.reg_write, bus2.mem_write,
                     bus2.ir_write, bus2.mem_req, bus2.adr_src, bus2.result_src, bus2.alu_src_a,
                     bus2.alu_src_b, bus2.alu_op, bus2.illegal_op, bus2.retire};

    int          ms   [N];
    logic [15:0] pth  [N];
    int          pidx [N];
    int          ret_cnt [N];
    int          mw_cnt  [N];
    int          irw_cnt [N];
    int          tests_run = 0;
    int          tests_failed = 0;

    // Remaining state path after DECODE: {length, s0, s1, s2}; length 0 = illegal.
    function automatic logic [15:0] classify(input logic [6:0] o, input bit ext);
        case (o)
            OP_R:         return 16'h2670;
            OP_I:         return 16'h2870;
            OP_LW, OP_SW: return 16'h1200;
            OP_BEQ:       return 16'h1A00;
            OP_JAL:       return 16'h2970;
            OP_JALR:      return ext ? 16'h3BC7 : 16'h0000;
            OP_LUI:       return ext ? 16'h2D70 : 16'h0000;
            OP_AUIPC:     return ext ? 16'h2E70 : 16'h0000;
            default:      return 16'h0000;
        endcase
    endfunction

    function automatic int nib(input logic [15:0] c, input int k);
        return int'(c[11-4*k -: 4]);
    endfunction

    function automatic logic [20:0] exp_out(input int s, input bit rdy, input bit nop_ret);
        logic pcu, br, rw, mw, irw, mrq, ads, ill, ret;
        logic [1:0] res, a, b, ao;
        {pcu, br, rw, mw, irw, mrq, ads, ill, ret} = '0;
        res = 2'd0; a = 2'd0; b = 2'd0; ao = 2'd0;
        case (s)
            0:  begin mrq = 1; b = 2; res = 2; irw = rdy; pcu = rdy; end
            1:  begin a = 1; b = 1; ret = nop_ret; end
            2:  begin a = 2; b = 1; end
            3:  begin ads = 1; mrq = 1; end
            4:  begin res = 1; rw = 1; ret = 1; end
            5:  begin ads = 1; mrq = 1; mw = 1; ret = rdy; end
            6:  begin a = 2; ao = 2; end
            7:  begin rw = 1; ret = 1; end
            8:  begin a = 2; b = 1; ao = 2; end
            9:  begin a = 1; b = 2; pcu = 1; end
            10: begin a = 2; ao = 1; br = 1; ret = 1; end
            11: begin a = 2; b = 1; end
            12: begin a = 1; b = 2; pcu = 1; end
            13: begin a = 3; b = 1; end
            14: begin a = 1; b = 1; end
            default: ill = 1;
        endcase
        return {4'(s), pcu, br, rw, mw, irw, mrq, ads, res, a, b, ao, ill, ret};
    endfunction

    task automatic model_step(input int i);
        bit rdy;
        int s;
        logic [15:0] c;
        rdy = mem_ready | !P_MW[i];
        s = ms[i];
        if (s == 15) begin
        end else if (s == 0) begin
            if (rdy) ms[i] = 1;
        end else if (s == 1) begin
            c = classify(op, P_EXT[i]);
            if (c[15:12] != 4'd0) begin
                pth[i] = c; pidx[i] = 0; ms[i] = nib(c, 0);
            end else begin
                ms[i] = P_TRAP[i] ? 15 : 0;
            end
        end else if (s == 2) begin
            pth[i] = (op == OP_LW) ? 16'h2340 : 16'h1500;
            pidx[i] = 0;
            ms[i] = nib(pth[i], 0);
        end else if ((s == 3 || s == 5) && !rdy) begin
        end else begin
            pidx[i]++;
            ms[i] = (pidx[i] < int'(pth[i][15:12])) ? nib(pth[i], pidx[i]) : 0;
        end
    endtask

    task automatic compare_all();
        logic [20:0] e;
        logic [15:0] c;
        bit rdy;
        for (int i = 0; i < N; i++) begin
            rdy = mem_ready | !P_MW[i];
            c = classify(op, P_EXT[i]);
            e = exp_out(ms[i], rdy, (c[15:12] == 4'd0) && !P_TRAP[i]);
            tests_run++;
            if (act[i] !== e) begin
                tests_failed++;
                $display("FAIL cycle dut%0d t=%0t: outputs got %h, expected %h (model state %0d)",
                         i, $time, act[i], e, ms[i]);
            end
            ret_cnt[i] += int'(act[i][0]);
            mw_cnt[i]  += int'(act[i][13]);
            irw_cnt[i] += int'(act[i][12]);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] o, input logic mr);
        op = o;
        mem_ready = mr;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (reset) ms[i] = 0;
            else       model_step(i);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) ms[i] = 0;
        set_in(7'd0, 1'b1);
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [6:0] prog_op  [8] = '{OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_LW, OP_SW, OP_BEQ, OP_JALR};
    int         prog_len [8] = '{4, 4, 4, 4, 5, 4, 3, 5};
    int         r0, m0, i0, r2;

    initial begin
        for (int i = 0; i < N; i++) begin
            ms[i] = 0; pth[i] = 16'h0; pidx[i] = 0;
            ret_cnt[i] = 0; mw_cnt[i] = 0; irw_cnt[i] = 0;
        end

        do_reset();
        set_in(7'd0, 1'b1);
        chk("reset_state", 32'(bus0.state_o), 0);
        chk("reset_ir_write", 32'(bus0.ir_write), 1);
        chk("reset_mem_req", 32'(bus0.mem_req), 1);

        // add, with op scrambled outside DECODE
        r0 = ret_cnt[0];
        set_in(OP_BAD, 1'b1); tick();
        set_in(OP_R, 1'b1);   chk("add_decode_state", 32'(bus0.state_o), 1); tick();
        set_in(OP_BAD, 1'b1); chk("add_execr_state", 32'(bus0.state_o), 6);
        chk("add_execr_aluop", 32'(bus0.alu_op), 2); tick();
        set_in(OP_BAD, 1'b1); chk("add_wb_regwrite", 32'(bus0.reg_write), 1);
        chk("add_wb_retire", 32'(bus0.retire), 1); tick();
        chk("add_done_state", 32'(bus0.state_o), 0);
        chk("add_retires", 32'(ret_cnt[0] - r0), 1);

        // lw with memory stalls: 3 in FETCH, 2 in MEMREAD -> 10 cycles
        do_reset();
        r0 = ret_cnt[0]; i0 = irw_cnt[0];
        set_in(OP_LW, 1'b0); chk("lw_stall_irw", 32'(bus0.ir_write), 0); tick();
        set_in(OP_LW, 1'b0); chk("lw_nowait_decode", 32'(bus2.state_o), 1); tick();
        set_in(OP_LW, 1'b0); tick();
        set_in(OP_LW, 1'b1); chk("lw_accept_irw", 32'(bus0.ir_write), 1); tick();
        set_in(OP_LW, 1'b1); tick();
        set_in(OP_LW, 1'b1); tick();
        set_in(OP_LW, 1'b0); chk("lw_memread_state", 32'(bus0.state_o), 3); tick();
        set_in(OP_LW, 1'b0); tick();
        set_in(OP_LW, 1'b1); tick();
        set_in(OP_LW, 1'b1); chk("lw_memwb_state", 32'(bus0.state_o), 4); tick();
        chk("lw_done_state", 32'(bus0.state_o), 0);
        chk("lw_retires", 32'(ret_cnt[0] - r0), 1);
        chk("lw_irw_cycles", 32'(irw_cnt[0] - i0), 1);

        // sw with 4 stall cycles in MEMWRITE, then beq
        do_reset();
        r0 = ret_cnt[0]; m0 = mw_cnt[0];
        for (int k = 0; k < 3; k++) begin set_in(OP_SW, 1'b1); tick(); end
        set_in(OP_SW, 1'b0);
        chk("sw_stall_memwrite", 32'(bus0.mem_write), 1);
        chk("sw_stall_retire", 32'(bus0.retire), 0);
        tick();
        for (int k = 0; k < 3; k++) begin set_in(OP_SW, 1'b0); tick(); end
        set_in(OP_SW, 1'b1); chk("sw_accept_retire", 32'(bus0.retire), 1); tick();
        chk("sw_done_state", 32'(bus0.state_o), 0);
        chk("sw_memwrite_cycles", 32'(mw_cnt[0] - m0), 5);
        chk("sw_retires", 32'(ret_cnt[0] - r0), 1);
        set_in(OP_BEQ, 1'b1); tick();
        set_in(OP_BEQ, 1'b1); tick();
        set_in(OP_BEQ, 1'b1); chk("beq_state", 32'(bus0.state_o), 10);
        chk("beq_branch", 32'(bus0.branch), 1); tick();
        chk("beq_done_state", 32'(bus0.state_o), 0);

        // reset asserted in the middle of a stalled store
        do_reset();
        for (int k = 0; k < 3; k++) begin set_in(OP_SW, 1'b1); tick(); end
        set_in(OP_SW, 1'b0);
        chk("rst_pre_memwrite", 32'(bus0.mem_write), 1);
        reset = 1'b1;
        for (int i = 0; i < N; i++) ms[i] = 0;
        #1;
        chk("rst_async_state", 32'(bus0.state_o), 0);
        chk("rst_async_memwrite", 32'(bus0.mem_write), 0);
        chk("rst_irw_notready", 32'(bus0.ir_write), 0);
        set_in(OP_SW, 1'b1);
        chk("rst_irw_ready", 32'(bus0.ir_write), 1);
        tick();
        reset = 1'b0;
        set_in(7'd0, 1'b1);
        chk("rst_release_irw", 32'(bus0.ir_write), 1);

        // jalr: dut0 decodes, dut1 traps, dut2 retires as nop
        do_reset();
        set_in(OP_JALR, 1'b1); tick();
        set_in(OP_JALR, 1'b1); chk("jalr_nop_retire", 32'(bus2.retire), 1); tick();
        set_in(OP_JALR, 1'b1); chk("jalr_adr_state", 32'(bus0.state_o), 11);
        chk("jalr_noext_trap", 32'(bus1.state_o), 15); tick();
        set_in(OP_JALR, 1'b1); chk("jalr_state", 32'(bus0.state_o), 12);
        chk("jalr_pc_update", 32'(bus0.pc_update), 1);
        chk("jalr_srcs", {26'd0, bus0.result_src, bus0.alu_src_a, bus0.alu_src_b}, 32'b00_01_10);
        tick();
        set_in(OP_JALR, 1'b1); chk("jalr_wb_state", 32'(bus0.state_o), 7); tick();
        for (int k = 0; k < 4; k++) begin set_in(OP_R, 1'b1); tick(); end
        chk("jalr_trap_held", 32'(bus1.illegal_op), 1);

        // illegal opcode: dut0 traps and stays, dut2 treats as nop
        do_reset();
        set_in(OP_BAD, 1'b1); tick();
        set_in(OP_BAD, 1'b1); chk("ill_trap_noretire", 32'(bus0.retire), 0);
        chk("ill_nop_retire", 32'(bus2.retire), 1); tick();
        set_in(OP_BAD, 1'b1); chk("ill_nop_back", 32'(bus2.state_o), 0);
        for (int k = 0; k < 20; k++) begin set_in(OP_R, 1'b1); tick(); end
        chk("ill_trap_state", 32'(bus0.state_o), 15);
        chk("ill_trap_flag", 32'(bus0.illegal_op), 1);
        do_reset();
        set_in(7'd0, 1'b1);
        chk("ill_reset_exit", 32'(bus0.state_o), 0);

        // back-to-back program with memory always ready
        do_reset();
        r0 = ret_cnt[0]; r2 = ret_cnt[2];
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < prog_len[p]; k++) begin
                set_in(prog_op[p], 1'b1);
                tick();
            end
        end
        chk("prog_done_state", 32'(bus0.state_o), 0);
        chk("prog_retires", 32'(ret_cnt[0] - r0), 8);
        chk("prog_noext_retired", 32'(ret_cnt[2] - r2 > 0), 1);

        set_in(7'd0, 1'b1);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
